board_arbiter: RTL

BOARD_ARBITER -- requirements
Module: board_arbiter

---
 rtl/board_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/board_arbiter.sv
// Three-client round-robin arbiter for a shared board memory port with a locked, registered one-hot grant.
// Define BOARD_ARB_TIMEOUT_EN to preempt an owner after HOLD_MAX owned cycles when another client is waiting.
module board_arbiter #(
  parameter int boardWidth  = 8,
  parameter int boardHeight = 8,
  parameter int HOLD_MAX    = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [2:0]                     req,
  input  logic [$clog2(boardWidth)-1:0]  reqX0,
  input  logic [$clog2(boardWidth)-1:0]  reqX1,
  input  logic [$clog2(boardWidth)-1:0]  reqX2,
  input  logic [$clog2(boardHeight)-1:0] reqY0,
  input  logic [$clog2(boardHeight)-1:0] reqY1,
  input  logic [$clog2(boardHeight)-1:0] reqY2,
  input  logic [2:0]                     reqWe,
  input  logic [2:0]                     reqWd,
  output logic [2:0]                     gnt,
  output logic [$clog2(boardWidth)-1:0]  x,
  output logic [$clog2(boardHeight)-1:0] y,
  output logic                           we,
  output logic                           wd,
  output logic                           busy,
  output logic [1:0]                     owner
);

  if (HOLD_MAX < 2) begin : g_bad_hold
    $error("board_arbiter: HOLD_MAX must be at least 2");
  end

  typedef enum logic {IDLE, OWNED} state_t;

  state_t     state, state_n;
  logic [1:0] cur, cur_n;
  logic [1:0] last, last_n;
  logic [2:0] gnt_n;
  logic [2:0] others;
  logic       owner_req;
  logic       grant_chg;

  // First requester strictly after 'from', wrapping 2 -> 0.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] from);
    logic [1:0] pick;
    logic       found;
    pick  = from;
    found = 1'b0;
    for (int unsigned k = 1; k <= 3; k++) begin
      int unsigned c;
      c = (int'(from) + k) % 3;
      if (!found && r[c]) begin
        pick  = 2'(c);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // gnt is one-hot on cur while owned, so masking by gnt avoids indexing req with cur.
  assign owner_req = |(req & gnt);
  assign others    = req & ~gnt;

`ifdef BOARD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);
  logic [CW-1:0] cnt;
`endif

  always_comb begin
    state_n   = state;
    cur_n     = cur;
    last_n    = last;
    grant_chg = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n   = OWNED;
          cur_n     = rr_pick(req, last);
          grant_chg = 1'b1;
        end
      end
      OWNED: begin
        if (!owner_req) begin
          last_n    = cur;
          grant_chg = 1'b1;
          if (|others) cur_n = rr_pick(others, cur);
          else         state_n = IDLE;
        end
`ifdef BOARD_ARB_TIMEOUT_EN
        else if (cnt == HOLD_LAST && |others) begin
          last_n    = cur;
          cur_n     = rr_pick(others, cur);
          grant_chg = 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
    gnt_n = (state_n == OWNED) ? (3'b001 << cur_n) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cur   <= '0;
      last  <= 2'd2;
      gnt   <= '0;
    end else begin
      state <= state_n;
      cur   <= cur_n;
      last  <= last_n;
      gnt   <= gnt_n;
    end
  end

`ifdef BOARD_ARB_TIMEOUT_EN
  // Saturates at HOLD_LAST so a late-arriving request preempts on the following edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (grant_chg || state_n == IDLE)
      cnt <= '0;
    else if (state == OWNED && cnt != HOLD_LAST)
      cnt <= cnt + 1'b1;
  end
`endif

  assign busy  = |gnt;
  assign owner = busy ? cur : 2'd3;
  assign we    = |(reqWe & gnt);

  always_comb begin
    x  = '0;
    y  = '0;
    wd = 1'b0;
    if (busy) begin
      case (cur)
        2'd0:    begin x = reqX0; y = reqY0; wd = reqWd[0]; end
        2'd1:    begin x = reqX1; y = reqY1; wd = reqWd[1]; end
        default: begin x = reqX2; y = reqY2; wd = reqWd[2]; end
      endcase
    end
  end

endmodule
